// File: rtl/sd_bus_sched.sv
// SD card bus scheduler: sequences the init engine, then arbitrates sector writes
// with bounded retries, timeouts and inter-operation bus gaps.
module sd_bus_sched #(
    parameter logic [23:0] INIT_TIMEOUT = 24'd500000,
    parameter logic [23:0] WR_TIMEOUT   = 24'd1000000,
    parameter logic [3:0]  MAX_RETRY    = 4'd3,
    parameter logic [3:0]  GAP_CYCLES   = 4'd8
) (
    input  logic        SD_clk,
    input  logic        rst,
    output logic        init_rst_n,
    input  logic        init_done,
    input  logic        init_cs,
    input  logic        init_datain,
    output logic        wr_start,
    output logic [31:0] wr_addr,
    input  logic        wr_done,
    input  logic        wr_err,
    input  logic        wr_cs,
    input  logic        wr_datain,
    output logic        SD_cs,
    output logic        SD_datain,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        card_ok,
    output logic        busy,
    output logic        fatal,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        RST_INIT, INIT_WAIT, GAP, IDLE, WR_ISSUE, WR_WAIT, FAIL
    } state_t;

    typedef enum logic [1:0] {SEL_NONE, SEL_INIT, SEL_WR} sel_t;

    state_t      r_state;
    state_t      w_next;
    sel_t        r_sel;
    logic [1:0]  r_rst_cnt;
    logic [23:0] r_tmo;
    logic [3:0]  r_retry;
    logic [3:0]  r_gap;
    logic [7:0]  r_err_cnt;
    logic        r_card_ok;
    logic [31:0] r_wr_addr;

    logic w_init_fail;
    logic w_wr_ok;
    logic w_wr_fail;
    logic w_retry_ok;
    logic w_gap_end;
    logic w_err_evt;

    function automatic sel_t sel_of(input state_t s);
        case (s)
            RST_INIT, INIT_WAIT: sel_of = SEL_INIT;
            WR_ISSUE, WR_WAIT:   sel_of = SEL_WR;
            default:             sel_of = SEL_NONE;
        endcase
    endfunction

    // A simultaneous done/err is an error; a done in the timeout cycle still wins.
    assign w_init_fail = !init_done && (r_tmo == INIT_TIMEOUT - 24'd1);
    assign w_wr_ok     = wr_done && !wr_err;
    assign w_wr_fail   = wr_err || (!wr_done && (r_tmo == WR_TIMEOUT - 24'd1));
    assign w_retry_ok  = r_retry < MAX_RETRY;
    assign w_gap_end   = ({1'b0, r_gap} + 5'd1) >= {1'b0, GAP_CYCLES};
    assign w_err_evt   = ((r_state == INIT_WAIT) && w_init_fail) ||
                         ((r_state == WR_WAIT) && w_wr_fail);

    always_ff @(posedge SD_clk or posedge rst) begin
        if (rst) begin
            r_state <= RST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RST_INIT:  if (r_rst_cnt == 2'd3) w_next = INIT_WAIT;
            INIT_WAIT: begin
                if (init_done)        w_next = GAP;
                else if (w_init_fail) w_next = w_retry_ok ? RST_INIT : FAIL;
            end
            GAP:       if (w_gap_end) w_next = IDLE;
            IDLE:      if (req_valid) w_next = WR_ISSUE;
            WR_ISSUE:  w_next = WR_WAIT;
            WR_WAIT: begin
                if (w_wr_ok)        w_next = GAP;
                else if (w_wr_fail) w_next = w_retry_ok ? WR_ISSUE : FAIL;
            end
            FAIL:      w_next = FAIL;
            default:   w_next = RST_INIT;
        endcase
    end

    always_comb begin
        init_rst_n = (r_state != RST_INIT);
        wr_start   = (r_state == WR_ISSUE);
        busy       = (r_state == WR_ISSUE) || (r_state == WR_WAIT);
        fatal      = (r_state == FAIL);
        req_ready  = (r_state == IDLE) && !fatal;
        card_ok    = r_card_ok;
        err_cnt    = r_err_cnt;
        wr_addr    = r_wr_addr;
        SD_cs      = 1'b1;
        SD_datain  = 1'b1;
        case (r_sel)
            SEL_INIT: begin SD_cs = init_cs; SD_datain = init_datain; end
            SEL_WR:   begin SD_cs = wr_cs;   SD_datain = wr_datain;   end
            default:  begin SD_cs = 1'b1;    SD_datain = 1'b1;        end
        endcase
    end

    // Bus select tracks the next state so ownership changes on the same edge as r_state.
    always_ff @(posedge SD_clk or posedge rst) begin
        if (rst) begin
            r_sel     <= SEL_NONE;
            r_rst_cnt <= 2'd0;
            r_tmo     <= 24'd0;
            r_retry   <= 4'd0;
            r_gap     <= 4'd0;
            r_err_cnt <= 8'd0;
            r_card_ok <= 1'b0;
            r_wr_addr <= 32'd0;
        end else begin
            r_sel     <= sel_of(w_next);
            r_rst_cnt <= (r_state == RST_INIT) ? r_rst_cnt + 2'd1 : 2'd0;
            r_gap     <= (r_state == GAP) ? r_gap + 4'd1 : 4'd0;

            if ((r_state == INIT_WAIT) || (r_state == WR_WAIT)) begin
                if (r_tmo != 24'hFF_FFFF) r_tmo <= r_tmo + 24'd1;
            end else begin
                r_tmo <= 24'd0;
            end

            if ((r_state == INIT_WAIT) && init_done) begin
                r_retry <= 4'd0;
            end else if ((r_state == IDLE) && req_valid) begin
                r_retry <= 4'd0;
            end else if (w_err_evt && w_retry_ok) begin
                r_retry <= r_retry + 4'd1;
            end

            if (w_err_evt && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;

            if ((r_state == INIT_WAIT) && init_done) r_card_ok <= 1'b1;
            else if (w_next == FAIL)                 r_card_ok <= 1'b0;

            if ((r_state == IDLE) && req_valid) r_wr_addr <= req_addr;
        end
    end

endmodule

// File: tb/tb_sd_bus_sched.sv
// Directed bench for sd_bus_sched: three instances share stimulus and differ in
// init timeout and retry budget.
module tb_sd_bus_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0, init_cs = 1'b0, init_datain = 1'b0;
    logic        wr_done = 1'b0, wr_err = 1'b0, wr_cs = 1'b0, wr_datain = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'd0;

    logic        a_init_rst_n, a_wr_start, a_sd_cs, a_sd_datain, a_req_ready, a_card_ok, a_busy, a_fatal;
    logic [31:0] a_wr_addr;
    logic [7:0]  a_err_cnt;
    logic        b_init_rst_n, b_wr_start, b_sd_cs, b_sd_datain, b_req_ready, b_card_ok, b_busy, b_fatal;
    logic [31:0] b_wr_addr;
    logic [7:0]  b_err_cnt;
    logic        c_init_rst_n, c_wr_start, c_sd_cs, c_sd_datain, c_req_ready, c_card_ok, c_busy, c_fatal;
    logic [31:0] c_wr_addr;
    logic [7:0]  c_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sd_bus_sched #(.INIT_TIMEOUT(24'd2000), .WR_TIMEOUT(24'd200), .MAX_RETRY(4'd3), .GAP_CYCLES(4'd8)) u_a (
        .SD_clk(clk), .rst(rst), .init_rst_n(a_init_rst_n), .init_done(init_done), .init_cs(init_cs),
        .init_datain(init_datain), .wr_start(a_wr_start), .wr_addr(a_wr_addr), .wr_done(wr_done),
        .wr_err(wr_err), .wr_cs(wr_cs), .wr_datain(wr_datain), .SD_cs(a_sd_cs), .SD_datain(a_sd_datain),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(a_req_ready), .card_ok(a_card_ok),
        .busy(a_busy), .fatal(a_fatal), .err_cnt(a_err_cnt));

    sd_bus_sched #(.INIT_TIMEOUT(24'd100), .WR_TIMEOUT(24'd200), .MAX_RETRY(4'd3), .GAP_CYCLES(4'd8)) u_b (
        .SD_clk(clk), .rst(rst), .init_rst_n(b_init_rst_n), .init_done(init_done), .init_cs(init_cs),
        .init_datain(init_datain), .wr_start(b_wr_start), .wr_addr(b_wr_addr), .wr_done(wr_done),
        .wr_err(wr_err), .wr_cs(wr_cs), .wr_datain(wr_datain), .SD_cs(b_sd_cs), .SD_datain(b_sd_datain),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(b_req_ready), .card_ok(b_card_ok),
        .busy(b_busy), .fatal(b_fatal), .err_cnt(b_err_cnt));

    sd_bus_sched #(.INIT_TIMEOUT(24'd2000), .WR_TIMEOUT(24'd200), .MAX_RETRY(4'd0), .GAP_CYCLES(4'd8)) u_c (
        .SD_clk(clk), .rst(rst), .init_rst_n(c_init_rst_n), .init_done(init_done), .init_cs(init_cs),
        .init_datain(init_datain), .wr_start(c_wr_start), .wr_addr(c_wr_addr), .wr_done(wr_done),
        .wr_err(wr_err), .wr_cs(wr_cs), .wr_datain(wr_datain), .SD_cs(c_sd_cs), .SD_datain(c_sd_datain),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(c_req_ready), .card_ok(c_card_ok),
        .busy(c_busy), .fatal(c_fatal), .err_cnt(c_err_cnt));

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        init_cs = 1'b0; init_datain = 1'b0; wr_cs = 1'b0; wr_datain = 1'b0;
        @(negedge clk);
        flags = {a_init_rst_n, a_wr_start, a_req_ready, a_card_ok, a_busy, a_fatal, a_sd_cs, a_sd_datain};
        n_checks++; if (flags !== 8'b0000_0011) begin n_errors++; $display("FAIL reset_flags: got %b want 00000011", flags); end
        n_checks++; if (a_wr_addr !== 32'd0) begin n_errors++; $display("FAIL reset_wr_addr: got %h want 0", a_wr_addr); end
        n_checks++; if (a_err_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_err_cnt: got %0d want 0", a_err_cnt); end
    endtask

    task automatic test_init_timeout();
        int lows, rises;
        logic prev;
        init_done = 1'b0;
        do_reset();
        lows = 0; rises = 0; prev = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!b_init_rst_n) lows++;
            if (b_init_rst_n && !prev) rises++;
            prev = b_init_rst_n;
        end
        n_checks++; if (lows != 16) begin n_errors++; $display("FAIL init_tmo_low_cycles: got %0d want 16", lows); end
        n_checks++; if (rises != 4) begin n_errors++; $display("FAIL init_tmo_pulses: got %0d want 4", rises); end
        n_checks++; if (b_err_cnt !== 8'd4) begin n_errors++; $display("FAIL init_tmo_err_cnt: got %0d want 4", b_err_cnt); end
        n_checks++; if (b_fatal !== 1'b1) begin n_errors++; $display("FAIL init_tmo_fatal: got %b want 1", b_fatal); end
        n_checks++; if ({b_card_ok, b_req_ready, b_busy} !== 3'b000) begin n_errors++; $display("FAIL init_tmo_flags: got %b want 000", {b_card_ok, b_req_ready, b_busy}); end
        init_cs = 1'b0; #1;
        n_checks++; if (b_sd_cs !== 1'b1) begin n_errors++; $display("FAIL init_tmo_sd_cs: got %b want 1", b_sd_cs); end
        n_checks++; if (a_err_cnt !== 8'd0) begin n_errors++; $display("FAIL init_long_tmo_err_cnt: got %0d want 0", a_err_cnt); end
    endtask

    task automatic test_init_success();
        int n;
        init_done = 1'b0; init_cs = 1'b1; init_datain = 1'b1; wr_cs = 1'b1; wr_datain = 1'b1;
        do_reset();
        @(negedge clk); @(negedge clk);
        init_cs = 1'b0; init_datain = 1'b0; #1;
        n_checks++; if (a_init_rst_n !== 1'b0) begin n_errors++; $display("FAIL rst_init_rst_n: got %b want 0", a_init_rst_n); end
        n_checks++; if ({a_sd_cs, a_sd_datain} !== 2'b00) begin n_errors++; $display("FAIL rst_init_bus: got %b want 00", {a_sd_cs, a_sd_datain}); end
        repeat (1000) @(posedge clk);
        #1 init_cs = 1'b1; init_datain = 1'b1; wr_cs = 1'b0; wr_datain = 1'b0;
        #1;
        n_checks++; if ({a_sd_cs, a_sd_datain} !== 2'b11) begin n_errors++; $display("FAIL init_wait_bus: got %b want 11", {a_sd_cs, a_sd_datain}); end
        n_checks++; if (a_card_ok !== 1'b0) begin n_errors++; $display("FAIL init_wait_card_ok: got %b want 0", a_card_ok); end
        init_done = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!a_card_ok && n < 10);
        init_done = 1'b0; init_cs = 1'b0; wr_cs = 1'b0;
        n_checks++; if (a_card_ok !== 1'b1) begin n_errors++; $display("FAIL init_card_ok: got %b want 1", a_card_ok); end
        n_checks++; if (a_req_ready !== 1'b0) begin n_errors++; $display("FAIL gap_req_ready: got %b want 0", a_req_ready); end
        n = 0;
        while (!a_req_ready && n < 20) begin
            @(negedge clk); n++;
            if (n == 4) begin
                #1;
                n_checks++; if (a_sd_cs !== 1'b1) begin n_errors++; $display("FAIL gap_sd_cs: got %b want 1", a_sd_cs); end
            end
        end
        n_checks++; if (n != 8) begin n_errors++; $display("FAIL init_gap_len: got %0d want 8", n); end
    endtask

    task automatic test_write_success();
        int n, pulses, busy_low;
        logic first_start;
        wr_cs = 1'b1; wr_datain = 1'b1;
        @(posedge clk); #1 req_addr = 32'h0000_1000; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0; req_addr = 32'hDEAD_BEEF;
        pulses = 0; busy_low = 0; first_start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0) first_start = a_wr_start;
            if (a_wr_start) pulses++;
            if (!a_busy) busy_low++;
            if (i == 10) begin
                wr_cs = 1'b0; wr_datain = 1'b0; init_cs = 1'b1; init_datain = 1'b1; #1;
                n_checks++; if ({a_sd_cs, a_sd_datain} !== 2'b00) begin n_errors++; $display("FAIL wr_wait_bus: got %b want 00", {a_sd_cs, a_sd_datain}); end
            end
        end
        wr_done = 1'b1;
        @(posedge clk); #1 wr_done = 1'b0;
        @(negedge clk);
        n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL wr_done_busy: got %b want 0", a_busy); end
        n = 0;
        while (!a_req_ready && n < 20) begin @(negedge clk); n++; end
        n_checks++; if (first_start !== 1'b1) begin n_errors++; $display("FAIL wr_start_timing: got %b want 1", first_start); end
        n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL wr_start_count: got %0d want 1", pulses); end
        n_checks++; if (busy_low != 0) begin n_errors++; $display("FAIL wr_busy_gaps: got %0d want 0", busy_low); end
        n_checks++; if (a_wr_addr !== 32'h0000_1000) begin n_errors++; $display("FAIL wr_addr: got %h want 00001000", a_wr_addr); end
        n_checks++; if (n != 8) begin n_errors++; $display("FAIL wr_gap_len: got %0d want 8", n); end
        n_checks++; if (a_err_cnt !== 8'd0) begin n_errors++; $display("FAIL wr_err_cnt: got %0d want 0", a_err_cnt); end
    endtask

    task automatic test_write_retry();
        int n, pulses;
        @(posedge clk); #1 req_addr = 32'h2345_6789; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0; req_addr = 32'd0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!a_wr_start && n < 20);
            if (a_wr_start) pulses++;
            n_checks++; if (a_wr_addr !== 32'h2345_6789) begin n_errors++; $display("FAIL retry%0d_wr_addr: got %h want 23456789", k, a_wr_addr); end
            for (int j = 0; j < 5; j++) begin @(negedge clk); if (a_wr_start) pulses++; end
            if (k < 2) wr_err = 1'b1; else wr_done = 1'b1;
            @(posedge clk); #1 wr_err = 1'b0; wr_done = 1'b0;
        end
        n = 0;
        while (!a_req_ready && n < 20) begin @(negedge clk); n++; end
        n_checks++; if (pulses != 3) begin n_errors++; $display("FAIL retry_pulses: got %0d want 3", pulses); end
        n_checks++; if (a_err_cnt !== 8'd2) begin n_errors++; $display("FAIL retry_err_cnt: got %0d want 2", a_err_cnt); end
        n_checks++; if (a_fatal !== 1'b0) begin n_errors++; $display("FAIL retry_fatal: got %b want 0", a_fatal); end
        n_checks++; if (a_req_ready !== 1'b1) begin n_errors++; $display("FAIL retry_req_ready: got %b want 1", a_req_ready); end
    endtask

    task automatic test_simultaneous();
        int n;
        do_reset();
        @(posedge clk); #1 init_done = 1'b1;
        n = 0;
        while (!a_req_ready && n < 60) begin @(negedge clk); n++; end
        init_done = 1'b0;
        n_checks++; if (c_req_ready !== 1'b1) begin n_errors++; $display("FAIL sim_c_ready: got %b want 1", c_req_ready); end
        @(posedge clk); #1 req_addr = 32'h0000_0055; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        wr_done = 1'b1; wr_err = 1'b1; wr_cs = 1'b0; wr_datain = 1'b0;
        @(posedge clk); #1 wr_done = 1'b0; wr_err = 1'b0;
        @(negedge clk);
        n_checks++; if (c_fatal !== 1'b1) begin n_errors++; $display("FAIL sim_c_fatal: got %b want 1", c_fatal); end
        n_checks++; if ({c_card_ok, c_req_ready, c_busy} !== 3'b000) begin n_errors++; $display("FAIL sim_c_flags: got %b want 000", {c_card_ok, c_req_ready, c_busy}); end
        n_checks++; if ({c_sd_cs, c_sd_datain} !== 2'b11) begin n_errors++; $display("FAIL sim_c_bus: got %b want 11", {c_sd_cs, c_sd_datain}); end
        n_checks++; if (c_err_cnt !== 8'd1) begin n_errors++; $display("FAIL sim_c_err_cnt: got %0d want 1", c_err_cnt); end
        n_checks++; if ({a_wr_start, a_fatal} !== 2'b10) begin n_errors++; $display("FAIL sim_a_retry: got %b want 10", {a_wr_start, a_fatal}); end
        n_checks++; if (a_err_cnt !== 8'd1) begin n_errors++; $display("FAIL sim_a_err_cnt: got %0d want 1", a_err_cnt); end
        n_checks++; if (a_wr_addr !== 32'h0000_0055) begin n_errors++; $display("FAIL sim_a_wr_addr: got %h want 00000055", a_wr_addr); end
    endtask

    task automatic test_reset_mid_write();
        int pulses, rdy;
        logic [7:0] flags;
        @(negedge clk);
        init_cs = 1'b1; init_datain = 1'b1; #1;
        n_checks++; if ({a_busy, a_sd_cs, a_sd_datain} !== 3'b100) begin n_errors++; $display("FAIL mid_wr_bus: got %b want 100", {a_busy, a_sd_cs, a_sd_datain}); end
        rst = 1'b1; #1;
        flags = {a_init_rst_n, a_wr_start, a_req_ready, a_card_ok, a_busy, a_fatal, a_sd_cs, a_sd_datain};
        n_checks++; if (flags !== 8'b0000_0011) begin n_errors++; $display("FAIL mid_rst_flags: got %b want 00000011", flags); end
        n_checks++; if (a_wr_addr !== 32'd0) begin n_errors++; $display("FAIL mid_rst_wr_addr: got %h want 0", a_wr_addr); end
        n_checks++; if (a_err_cnt !== 8'd0) begin n_errors++; $display("FAIL mid_rst_err_cnt: got %0d want 0", a_err_cnt); end
        n_checks++; if (c_fatal !== 1'b0) begin n_errors++; $display("FAIL mid_rst_c_fatal: got %b want 0", c_fatal); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b1; req_addr = 32'h0000_0077; init_done = 1'b0;
        pulses = 0; rdy = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (a_wr_start) pulses++;
            if (a_req_ready) rdy++;
        end
        req_valid = 1'b0;
        n_checks++; if (pulses != 0) begin n_errors++; $display("FAIL post_rst_wr_start: got %0d want 0", pulses); end
        n_checks++; if (rdy != 0) begin n_errors++; $display("FAIL post_rst_req_ready: got %0d want 0", rdy); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init_timeout();
        test_init_success();
        test_write_success();
        test_write_retry();
        test_simultaneous();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sd_bus_sched.md
SD_BUS_SCHED -- requirements
Module: sd_bus_sched

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- INIT_TIMEOUT, 24'd500000: SD_clk cycles allowed for init_done after the init engine is released.
- WR_TIMEOUT, 24'd1000000: SD_clk cycles allowed for wr_done or wr_err after wr_start.
- MAX_RETRY, 4'd3: retries allowed per init attempt and per sector write.
- GAP_CYCLES, 4'd8: cycles with SD_cs=1 and SD_datain=1 between operations.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- SD_clk, in, 1: sole clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- init_rst_n, out, 1: active-low reset to the SD init engine.
- init_done, in, 1: init engine complete (level).
- init_cs, in, 1: init engine chip-select drive.
- init_datain, in, 1: init engine MOSI drive.
- wr_start, out, 1: one-cycle start pulse to the sector-write engine.
- wr_addr, out, 32: sector address for the current write.
- wr_done, in, 1: write-engine success pulse.
- wr_err, in, 1: write-engine failure pulse.
- wr_cs, in, 1: write engine chip-select drive.
- wr_datain, in, 1: write engine MOSI drive.
- SD_cs, out, 1: card chip select.
- SD_datain, out, 1: card MOSI.
- req_valid, in, 1: requester has a sector to write.
- req_addr, in, 32: requested sector address.
- req_ready, out, 1: scheduler accepts a request.
- card_ok, out, 1: initialization succeeded.
- busy, out, 1: a write is in progress.
- fatal, out, 1: retries exhausted (sticky).
- err_cnt, out, 8: total init and write errors seen, saturating.

Function
REQ-003 SHALL implement states RST_INIT, INIT_WAIT, GAP, IDLE, WR_ISSUE, WR_WAIT, FAIL, registered on rising SD_clk.
REQ-004 RST_INIT: SHALL hold init_rst_n=0 for 4 cycles, then go to INIT_WAIT with init_rst_n=1 and the timeout counter cleared.
REQ-005 INIT_WAIT: on init_done=1, SHALL set card_ok=1 and go to GAP with retry count cleared.
- On timeout counter reaching INIT_TIMEOUT-1, SHALL increment err_cnt.
- If retries < MAX_RETRY, SHALL increment retries and return to RST_INIT; otherwise go to FAIL.
REQ-006 GAP: SHALL count GAP_CYCLES cycles, then go to IDLE.
REQ-007 IDLE: SHALL drive req_ready=1 only in IDLE with fatal=0; req_ready SHALL be 0 in all other states.
- A request is accepted when req_valid=1 and req_ready=1.
- On acceptance, SHALL latch req_addr into wr_addr, clear retries, and go to WR_ISSUE.
REQ-008 WR_ISSUE: SHALL pulse wr_start=1 for exactly one cycle (the cycle after acceptance), clear the timeout counter, and go to WR_WAIT.
- busy SHALL be 1 from WR_ISSUE through the exit of WR_WAIT.
REQ-009 WR_WAIT: on wr_done with no wr_err, SHALL go to GAP.
- On wr_err, or timeout counter reaching WR_TIMEOUT-1, SHALL increment err_cnt.
- If retries < MAX_RETRY, SHALL increment retries and go to WR_ISSUE with wr_addr unchanged; otherwise go to FAIL.
REQ-010 If wr_done and wr_err assert in the same cycle, SHALL treat the event as an error.
REQ-011 SHALL ignore wr_done and wr_err outside WR_WAIT, and init_done outside INIT_WAIT.
REQ-012 FAIL: SHALL set fatal=1, card_ok=0, req_ready=0, and remain in FAIL until rst.
REQ-013 wr_addr SHALL stay stable from acceptance until the next acceptance.
REQ-014 Bus ownership SHALL follow a registered select updated with the state:
- RST_INIT and INIT_WAIT: SD_cs=init_cs, SD_datain=init_datain.
- WR_ISSUE and WR_WAIT: SD_cs=wr_cs, SD_datain=wr_datain.
- All other states: SD_cs=1, SD_datain=1.
- SD_cs and SD_datain SHALL be a combinational mux of the selected engine's signals.
REQ-015 err_cnt SHALL saturate at 8'hFF.
REQ-016 Timeout counters SHALL be 24 bits and SHALL not wrap.

Reset
REQ-017 While rst=1, SHALL hold: state=RST_INIT, init_rst_n=0, wr_start=0, wr_addr=0, req_ready=0, card_ok=0, busy=0, fatal=0, err_cnt=0, retries=0, SD_cs=1, SD_datain=1.
REQ-018 rst asserted mid-write SHALL abort immediately to the REQ-017 values; no wr_start pulse SHALL be issued until a new request is accepted after a successful re-initialization.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Init success: release rst; init_done=1 after 1000 cycles -> card_ok=1; req_ready=1 exactly 8 cycles after leaving INIT_WAIT.
- Init timeout: INIT_TIMEOUT=100, init_done held 0 -> init_rst_n pulses low 4 times (1 initial + 3 retries); then fatal=1, err_cnt=4.
- Write success: req_addr=32'h0000_1000, wr_done after 50 cycles -> single wr_start pulse, wr_addr=32'h1000, busy=1 throughout, 8-cycle gap, req_ready=1.
- Write retry: wr_err on the first two attempts, wr_done on the third -> three wr_start pulses with the same wr_addr, err_cnt=2, fatal=0.
- Simultaneous wr_done and wr_err with MAX_RETRY=0 -> FAIL, fatal=1, SD_cs=1.
- Bus mux and reset: toggle init_cs and wr_cs in every state -> SD_cs follows only the owning engine; rst during WR_WAIT -> all outputs at REQ-017 values in the same cycle.
